// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a first-word fall-through
// receive FIFO and sticky framing/overrun error flags.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          raw_rx_bitstream,
  input  logic                          host_ready,
  input  logic                          clear_err,
`ifdef UART_RX_PARITY_EN
  input  logic                          parity_odd,
  output logic                          parity_err,
`endif
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          framing_err,
  output logic                          overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] SAMPLE_PT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 stop_bad;
  logic [DATA_BITS-1:0] shreg;
  logic                 mid;
  logic                 fe_set;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 pe_set;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 ovr_set;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser; resets high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], raw_rx_bitstream};
  end

  // Mid-bit strobe and error-set events
  always_comb begin
    mid    = (timer == SAMPLE_PT);
    fe_set = (state == S_STOP) && mid && (stop_cnt == LAST_STOP) &&
             (!rx_s || stop_bad);
`ifdef UART_RX_PARITY_EN
    pe_set = (state == S_PARITY) && mid && ((^shreg ^ rx_s) != parity_odd);
`endif
  end

  // Frame reception state machine with free-running bit timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      stop_bad <= 1'b0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      timer <= timer + 1'b1;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            timer <= '0;
          end
        end
        S_START: begin
          bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
          if (mid) state <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (mid) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              stop_cnt <= 1'b0;
              stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state    <= S_PARITY;
`else
              state    <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (mid) begin
            par_bad <= pe_set;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (mid) begin
            stop_cnt <= ~stop_cnt;
            if (!rx_s) stop_bad <= 1'b1;
            if (stop_cnt == LAST_STOP) begin
              if (fe_set)       state <= S_BREAK;
`ifdef UART_RX_PARITY_EN
              else if (par_bad) state <= S_IDLE;
`endif
              else              state <= S_COMMIT;
            end
          end
        end
        S_BREAK:  if (rx_s) state <= S_IDLE;
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  // FIFO control: a push into a full FIFO survives only with a same-cycle pop
  always_comb begin
    rx_data_valid = (fifo_count != '0);
    full          = (fifo_count == FULL_CNT);
    push          = (state == S_COMMIT);
    pop           = rx_data_valid && host_ready;
    push_ok       = push && (!full || pop);
    ovr_set       = push && full && !pop;
    rx_data       = rx_data_valid ? mem[rd_ptr] : '0;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      framing_err <= fe_set  | (framing_err & ~clear_err);
      overrun     <= ovr_set | (overrun & ~clear_err);
`ifdef UART_RX_PARITY_EN
      parity_err  <= pe_set  | (parity_err & ~clear_err);
`endif
    end
  end

endmodule
